ccm_result_packer: RTL and testbench

Receive side of the 3x3 colour-matrix multiplier. Takes the three signed 38-bit row results plus valid and converts them back to unsigned OUT_W-bit pixel components: fixed-point round, arithmetic shift, clamp. Attaches frame position tags and buffers results in a small FIFO so the downstream video sink can apply back-pressure. Sits between the matrix multiplier and the frame writer / VGA path.

---
 rtl/ccm_result_packer_pkg.sv | 12 +
 rtl/ccm_sync_fifo.sv | 48 ++++
 rtl/ccm_result_packer.sv | 132 +++++++++++++
 tb/tb_ccm_result_packer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ccm_result_packer_pkg.sv
// Shared types and constants for the colour-matrix result packer and its FIFO.
package ccm_result_packer_pkg;
   localparam int CCM_RES_W     = 38;
   localparam int CCM_FRAC_BITS = 10;
   localparam int CCM_OUT_W     = 8;

   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } pix_tag_t;
endpackage

// File: rtl/ccm_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head data is read straight from storage.
module ccm_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_rd   = rd_en && !empty;
   // A write into a full FIFO is only accepted when a pop frees a slot in the same cycle.
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         if (do_wr && !do_rd)      count <= count + CW'(1);
         else if (!do_wr && do_rd) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/ccm_result_packer.sv
// Rounds, shifts and clamps matrix row results to pixel components, tags frame
// position and queues them for a back-pressuring video sink.
module ccm_result_packer
   import ccm_result_packer_pkg::*;
#(
   parameter int FRAC_BITS  = CCM_FRAC_BITS,
   parameter int OUT_W      = CCM_OUT_W,
   parameter int FRAME_W    = 320,
   parameter int FRAME_H    = 240,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic signed [CCM_RES_W-1:0] iA,
   input  logic signed [CCM_RES_W-1:0] iB,
   input  logic signed [CCM_RES_W-1:0] iC,
   input  logic                        iValid,
   output logic [OUT_W-1:0]            oR,
   output logic [OUT_W-1:0]            oG,
   output logic [OUT_W-1:0]            oB,
   output logic                        oValid,
   input  logic                        iReady,
   output logic                        oSof,
   output logic                        oEol,
   output logic                        oEof,
   output logic                        oOverflow,
   output logic                        oFrameDone
);
   localparam int SW = CCM_RES_W + 1;
   localparam int XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
   localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
   localparam int EW = 3 * OUT_W + 3;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic signed [SW-1:0] HALF = SW'(1) << (FRAC_BITS - 1);
   localparam logic signed [SW-1:0] MAXV = SW'((1 << OUT_W) - 1);

   function automatic logic signed [SW-1:0] round_shift(input logic signed [CCM_RES_W-1:0] v);
      logic signed [SW-1:0] sum;
      sum = {v[CCM_RES_W-1], v} + HALF;
      return sum >>> FRAC_BITS;
   endfunction

   function automatic logic [OUT_W-1:0] clamp(input logic signed [SW-1:0] s);
      if (s < 0)         return '0;
      else if (s > MAXV) return '1;
      else               return s[OUT_W-1:0];
   endfunction

   logic [XW-1:0]        x;
   logic [YW-1:0]        y;
   pix_tag_t             cur_tag;
   logic                 vld_p0, vld_p1;
   logic signed [SW-1:0] sa_p0, sb_p0, sc_p0;
   pix_tag_t             tag_p0, tag_p1;
   logic [OUT_W-1:0]     r_p1, g_p1, b_p1;
   logic [EW-1:0]        head;
   pix_tag_t             head_tag;
   logic                 fifo_full, fifo_empty, pop;
   logic [CW-1:0]        fifo_count;

   always_comb begin
      cur_tag     = '0;
      cur_tag.sof = (x == '0) && (y == '0);
      cur_tag.eol = (x == XW'(FRAME_W - 1));
      cur_tag.eof = cur_tag.eol && (y == YW'(FRAME_H - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         x      <= '0;
         y      <= '0;
      end else begin
         vld_p0 <= iValid;
         vld_p1 <= vld_p0;
         if (iValid) begin
            if (x == XW'(FRAME_W - 1)) begin
               x <= '0;
               y <= (y == YW'(FRAME_H - 1)) ? '0 : y + YW'(1);
            end else begin
               x <= x + XW'(1);
            end
         end
      end
   end

   // Stage p0: round and shift; stage p1: clamp to the output range.
   always_ff @(posedge clk) begin
      sa_p0  <= round_shift(iA);
      sb_p0  <= round_shift(iB);
      sc_p0  <= round_shift(iC);
      tag_p0 <= cur_tag;
      r_p1   <= clamp(sa_p0);
      g_p1   <= clamp(sb_p0);
      b_p1   <= clamp(sc_p0);
      tag_p1 <= tag_p0;
   end

   ccm_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (vld_p1),
      .wr_data ({r_p1, g_p1, b_p1, tag_p1}),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign oValid   = (fifo_count != '0);
   assign pop      = oValid && iReady;
   assign head_tag = head[2:0];
   // Mask the storage read while empty so idle outputs are a clean zero.
   assign oR   = fifo_empty ? '0 : head[EW-1 -: OUT_W];
   assign oG   = fifo_empty ? '0 : head[EW-1-OUT_W -: OUT_W];
   assign oB   = fifo_empty ? '0 : head[EW-1-2*OUT_W -: OUT_W];
   assign oSof = !fifo_empty && head_tag.sof;
   assign oEol = !fifo_empty && head_tag.eol;
   assign oEof = !fifo_empty && head_tag.eof;

   always_ff @(posedge clk) begin
      if (reset) begin
         oOverflow  <= 1'b0;
         oFrameDone <= 1'b0;
      end else begin
         if (vld_p1 && fifo_full && !pop) oOverflow <= 1'b1;
         oFrameDone <= pop && head_tag.eof;
      end
   end
endmodule

// File: tb/tb_ccm_result_packer.sv
// Directed and randomized bench for ccm_result_packer against a queue-based reference model.
module tb_ccm_result_packer;
   localparam int FW    = 4;
   localparam int FH    = 2;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, iValid, iReady;
   logic signed [37:0] iA, iB, iC;
   logic [7:0] oR, oG, oB;
   logic oValid, oSof, oEol, oEof, oOverflow, oFrameDone;

   ccm_result_packer #(.FRAC_BITS(10), .OUT_W(8), .FRAME_W(FW), .FRAME_H(FH), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .iA(iA), .iB(iB), .iC(iC), .iValid(iValid),
      .oR(oR), .oG(oG), .oB(oB), .oValid(oValid), .iReady(iReady),
      .oSof(oSof), .oEol(oEol), .oEof(oEof), .oOverflow(oOverflow), .oFrameDone(oFrameDone)
   );

   typedef struct {
      int r, g, b;
      bit sof, eol, eof;
   } ent_t;

   ent_t q[$];
   ent_t p0, p1;
   bit   p0v, p1v, exp_ovf, exp_fd;
   int   pix, tests, fails;
   int   fd_seen, sof_seen, eol_seen, eof_seen;

   // Component value: round half up to an integer, then clamp to 0..255.
   function automatic int comp(longint v);
      longint n, fl;
      n  = v + 512;
      fl = n / 1024;
      if (n < 0 && (n % 1024) != 0) fl = fl - 1;
      if (fl < 0) return 0;
      if (fl > 255) return 255;
      return int'(fl);
   endfunction

   function automatic longint rnd_val();
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) return -longint'($urandom_range(0, 100000));
      if (sel == 1) return (64'sd1 <<< 37) - 1;
      return longint'($urandom_range(0, 300 * 1024));
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("oValid", oValid, q.size() != 0);
      if (q.size() != 0) begin
         chk("oR", oR, q[0].r);
         chk("oG", oG, q[0].g);
         chk("oB", oB, q[0].b);
         chk("oSof", oSof, q[0].sof);
         chk("oEol", oEol, q[0].eol);
         chk("oEof", oEof, q[0].eof);
      end else begin
         chk("oR_idle", oR, 0);
         chk("oSof_idle", {oSof, oEol, oEof}, 0);
      end
      chk("oOverflow", oOverflow, exp_ovf);
      chk("oFrameDone", oFrameDone, exp_fd);
   endtask

   task automatic step(input bit v, input longint a, input longint b, input longint c,
                       input bit rdy, input bit rst = 1'b0);
      bit   pop;
      ent_t e;
      int   pos;
      reset  = rst;
      iValid = v;
      iA     = a[37:0];
      iB     = b[37:0];
      iC     = c[37:0];
      iReady = rdy;
      pop    = (q.size() != 0) && rdy && !rst;
      if (pop) begin
         sof_seen += int'(q[0].sof);
         eol_seen += int'(q[0].eol);
         eof_seen += int'(q[0].eof);
      end
      @(posedge clk);
      if (rst) begin
         q.delete();
         p0v = 0; p1v = 0; exp_ovf = 0; exp_fd = 0; pix = 0;
      end else begin
         exp_fd = 0;
         if (pop) begin
            e = q.pop_front();
            exp_fd = e.eof;
         end
         if (p1v) begin
            if (q.size() < DEPTH) q.push_back(p1);
            else exp_ovf = 1;
         end
         p1  = p0;
         p1v = p0v;
         p0v = v;
         if (v) begin
            pos = pix % (FW * FH);
            p0.r = comp(a); p0.g = comp(b); p0.b = comp(c);
            p0.sof = (pos == 0);
            p0.eol = ((pos % FW) == FW - 1);
            p0.eof = (pos == FW * FH - 1);
            pix++;
         end
      end
      #1;
      if (oFrameDone) fd_seen++;
      check_outputs();
   endtask

   task automatic idle(input bit rdy, input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, rdy);
   endtask

   initial begin
      tests = 0; fails = 0; pix = 0;
      p0v = 0; p1v = 0; exp_ovf = 0; exp_fd = 0;
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("rst_oValid", oValid, 0);
      chk("rst_outputs", {oR, oG, oB, oSof, oEol, oEof, oOverflow, oFrameDone}, 0);

      // Rounding and latency
      step(1, 102400, 102911, 102912, 0);
      chk("lat_t1", oValid, 0);
      step(0, 0, 0, 0, 0);
      chk("lat_t2", oValid, 0);
      step(0, 0, 0, 0, 0);
      chk("lat_t3", oValid, 1);
      chk("round_102400", oR, 100);
      chk("round_102911", oG, 100);
      chk("round_102912", oB, 101);
      idle(1, 1);
      step(1, -512, -1536, 1535, 0);
      idle(0, 2);
      chk("round_neg512", oR, 0);
      chk("round_neg1p5", oG, 0);
      chk("round_1p499", oB, 1);
      idle(1, 1);

      // Clamping
      step(1, -5000, 300 * 1024, 255 * 1024 + 511, 0);
      idle(0, 2);
      chk("clamp_neg", oR, 0);
      chk("clamp_300", oG, 255);
      chk("clamp_255p5", oB, 255);
      idle(1, 1);
      step(1, 0, 0, (64'sd1 <<< 37) - 1, 0);
      idle(0, 2);
      chk("clamp_maxpos", oB, 255);
      idle(1, 1);

      // Framing: two full 4x2 frames at full rate
      step(0, 0, 0, 0, 0, 1);
      fd_seen = 0; sof_seen = 0; eol_seen = 0; eof_seen = 0;
      for (int i = 0; i < 16; i++) step(1, rnd_val(), rnd_val(), rnd_val(), 1);
      idle(1, 5);
      chk("frame_done_pulses", fd_seen, 2);
      chk("frame_sof_count", sof_seen, 2);
      chk("frame_eol_count", eol_seen, 4);
      chk("frame_eof_count", eof_seen, 2);

      // Back-pressure and overflow
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) step(1, longint'(i) * 1024, 0, 0, 0);
      idle(0, 2);
      chk("ovf_set", oOverflow, 1);
      for (int i = 0; i < DEPTH; i++) begin
         chk("pop_order", oR, i);
         step(0, 0, 0, 0, 1);
      end
      chk("ovf_drained", oValid, 0);
      chk("ovf_sticky", oOverflow, 1);
      for (int i = 0; i < 8; i++) step(1, rnd_val(), rnd_val(), rnd_val(), 1);
      idle(1, 4);
      step(0, 0, 0, 0, 0, 1);
      chk("ovf_cleared", oOverflow, 0);

      // Full FIFO with simultaneous write and pop
      for (int i = 0; i < DEPTH; i++) step(1, rnd_val(), rnd_val(), rnd_val(), 0);
      idle(0, 2);
      chk("full_valid", oValid, 1);
      for (int i = 0; i < 20; i++) begin
         step(1, rnd_val(), rnd_val(), rnd_val(), 1);
         chk("full_no_ovf", oOverflow, 0);
      end
      idle(1, 12);

      // Reset mid-frame
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step(1, rnd_val(), rnd_val(), rnd_val(), 0);
      step(0, 0, 0, 0, 0, 1);
      chk("midrst_valid", oValid, 0);
      chk("midrst_ovf", oOverflow, 0);
      step(1, rnd_val(), rnd_val(), rnd_val(), 0);
      idle(0, 2);
      chk("midrst_sof", oSof, 1);
      idle(1, 2);

      // Random traffic
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 9) < 7, rnd_val(), rnd_val(), rnd_val(), $urandom_range(0, 9) < 6);
      idle(1, 12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
